// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory request interface: FSM encoding,
// default bus widths and the halfword alignment check.
package mem_if_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int CNT_WIDTH      = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } mem_state_t;

    // Byte addresses of 16-bit words must be even.
    function automatic logic addr_misaligned(input logic addr_lsb);
        return addr_lsb;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with registered read (read-before-write).
module mem_array #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 16,
    parameter     INIT_FILE  = ""
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write port plus registered read of the old contents at the same index.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[widx] <= wdata;
        end
        rdata <= r_mem[widx];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for load/store/push/pop requests from the memory stage.
// Accepts one request at a time, waits LATENCY cycles, then pulses rvalid.
//
//   state  | meaning
//   S_IDLE | ready for a new request
//   S_WAIT | request captured, latency counter running down
//   S_RESP | one-cycle response, rvalid high
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-2:0] DEPTH_WORDS = (ADDR_WIDTH-1)'(DEPTH);

    mem_state_t             r_state, w_next_state;
    logic [CNT_WIDTH-1:0]   r_cnt, w_next_cnt;
    logic                   r_wr;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic                   r_err;
    logic [DATA_WIDTH-1:0]  r_rdata_hold;

    logic                   w_accept;
    logic                   w_enter_resp;
    logic                   w_acc_wr;
    logic [ADDR_WIDTH-1:0]  w_acc_addr;
    logic [DATA_WIDTH-1:0]  w_acc_wdata;
    logic                   w_acc_err;
    logic                   w_we;
    logic [IDX_W-1:0]       w_widx;
    logic [DATA_WIDTH-1:0]  w_arr_rdata;
    logic [DATA_WIDTH-1:0]  w_resp_data;

    assign w_accept = (r_state == S_IDLE) && req;

    // With LATENCY=1 the array is accessed on the acceptance edge itself, so
    // the access uses the live inputs while idle and the captured copy later.
    assign w_acc_wr    = (r_state == S_IDLE) ? wr    : r_wr;
    assign w_acc_addr  = (r_state == S_IDLE) ? addr  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? wdata : r_wdata;
    assign w_acc_err   = addr_misaligned(w_acc_addr[0]) ||
                         (w_acc_addr[ADDR_WIDTH-1:1] >= DEPTH_WORDS);

    assign w_enter_resp = (w_next_state == S_RESP) && (r_state != S_RESP);
    // Gating with rst keeps a store from landing while reset is asserted.
    assign w_we   = w_enter_resp && w_acc_wr && !w_acc_err && rst;
    assign w_widx = w_acc_addr[IDX_W:1];

    mem_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_mem_array (
        .clk   (clk),
        .we    (w_we),
        .widx  (w_widx),
        .wdata (w_acc_wdata),
        .rdata (w_arr_rdata)
    );

    // Next-state and latency counter logic.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        w_next_state = S_RESP;
                    end else begin
                        w_next_state = S_WAIT;
                        w_next_cnt   = CNT_WIDTH'(LATENCY - 2);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Capture the request on acceptance only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_wr    <= wr;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    assign w_resp_data = r_err ? '0 : (r_wr ? r_wdata : w_arr_rdata);

    // Response status and data hold until the next response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err        <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            if (w_enter_resp) begin
                r_err <= w_acc_err;
            end
            if (r_state == S_RESP) begin
                r_rdata_hold <= w_resp_data;
            end
        end
    end

    assign ready  = (r_state == S_IDLE);
    assign busy   = (r_state != S_IDLE);
    assign rvalid = (r_state == S_RESP);
    assign err    = r_err;
    assign rdata  = (r_state == S_RESP) ? w_resp_data : r_rdata_hold;

endmodule
